// File: rtl/q_setpoint_scheduler.sv
// -----------------------------------------------------------------------------
// q_setpoint_scheduler
//
// Steps the charge-control top through a queue of q_desired setpoints. The host
// pushes setpoints into a small FIFO. When `go` arrives, the scheduler loads
// each entry in turn and runs the control loop (start/enable high). It holds
// that setpoint until `converged` has been stable for SETTLE_CYCLES consecutive
// cycles, or until the watchdog expires.
//
// Between setpoints the loop is disarmed for GAP_CYCLES cycles. This lets the
// downstream controller re-arm cleanly.
//
// Optional feature (macro Q_SCHED_RETRY_EN):
//   When defined, the first watchdog expiry on a setpoint reruns that same
//   setpoint once before faulting.
//   When undefined, any expiry faults immediately and no retry state exists.
//
// Ports
//   clk          in   1              system clock, rising edge
//   rst          in   1              synchronous, active-high reset
//   sp_valid     in   1              setpoint push request
//   sp_data      in   BUS_WIDTH      setpoint value
//   sp_ready     out  1              FIFO not full
//   go           in   1              start sequence / acknowledge fault
//   abort        in   1              stop and flush the queue
//   converged    in   1              convergence flag from the control loop
//   start        out  1              run request to top / resonant system
//   enable       out  1              loop enable to top
//   q_desired    out  BUS_WIDTH      active setpoint (holds outside RUN)
//   busy         out  1              scheduler not idle
//   sp_done      out  1              one-cycle pulse per accepted setpoint
//   timeout_err  out  1              sticky watchdog fault
//   fifo_count   out  clog2(DEPTH)+1 queued setpoints
// -----------------------------------------------------------------------------
module q_setpoint_scheduler #(
    parameter int BUS_WIDTH      = 10,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_W      = 14,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SETTLE_CYCLES  = 8,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sp_valid,
    input  logic [BUS_WIDTH-1:0]     sp_data,
    output logic                     sp_ready,
    input  logic                     go,
    input  logic                     abort,
    input  logic                     converged,
    output logic                     start,
    output logic                     enable,
    output logic [BUS_WIDTH-1:0]     q_desired,
    output logic                     busy,
    output logic                     sp_done,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0]     DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX    = '1;
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST    = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_GAP,
        S_FAULT
    } state_t;

    state_t state, state_n;

    // Setpoint FIFO storage.
    // Data is not reset; the pointers and count define validity.
    logic [BUS_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    logic [TIMEOUT_W-1:0] wdog;
    logic [SET_W-1:0]     settle;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 err_q;
    logic [BUS_WIDTH-1:0] q_reg;

    logic push, pop;
    logic settle_hit, wdog_hit;

    // `reload` means the coming LOAD reruns the current setpoint instead of
    // popping a new one. It only ever goes high when the retry feature exists.
    logic reload;

`ifdef Q_SCHED_RETRY_EN
    logic retry_used;

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_used <= 1'b0;
            reload     <= 1'b0;
        end else if (abort) begin
            retry_used <= 1'b0;
            reload     <= 1'b0;
        end else begin
            // RUN -> GAP happens only on the first timeout of a setpoint.
            if (state == S_RUN && state_n == S_GAP) begin
                retry_used <= 1'b1;
                reload     <= 1'b1;
            end
            if (state == S_LOAD) begin
                reload <= 1'b0;
            end
            // A completed setpoint, or one abandoned after a fault,
            // frees the next entry to get its own retry.
            if (state == S_DONE || (state == S_FAULT && state_n == S_GAP)) begin
                retry_used <= 1'b0;
            end
        end
    end
`else
    assign reload = 1'b0;
`endif

    assign sp_ready   = (count < DEPTH_C);
    assign push       = sp_valid && sp_ready && !abort;
    assign pop        = (state == S_LOAD) && !abort && !reload;
    assign settle_hit = (state == S_RUN) && converged && (settle == SETTLE_LAST);
    assign wdog_hit   = (state == S_RUN) && (wdog == WDOG_LAST);

    // Next-state logic.
    // Settling takes priority over a simultaneous watchdog expiry.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (go && count != '0) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                state_n = S_RUN;
            end
            S_RUN: begin
                if (settle_hit) begin
                    state_n = S_DONE;
                end else if (wdog_hit) begin
`ifdef Q_SCHED_RETRY_EN
                    state_n = retry_used ? S_FAULT : S_GAP;
`else
                    state_n = S_FAULT;
`endif
                end
            end
            S_DONE: begin
                state_n = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = (count != '0 || reload) ? S_LOAD : S_IDLE;
                end
            end
            S_FAULT: begin
                if (go) begin
                    state_n = S_GAP;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (abort) begin
            state_n = S_IDLE;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sp_data;
        end
    end

    // State register, FIFO bookkeeping, counters and the sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wdog    <= '0;
            settle  <= '0;
            gap_cnt <= '0;
            err_q   <= 1'b0;
            q_reg   <= '0;
        end else begin
            state <= state_n;

            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // Counters are only meaningful inside their own state.
            // Clearing them everywhere else covers the LOAD clear as well.
            if (state != S_RUN) begin
                wdog <= '0;
            end else if (wdog != WDOG_MAX) begin
                wdog <= wdog + 1'b1;
            end

            if (state != S_RUN || !converged) begin
                settle <= '0;
            end else if (settle != SETTLE_LAST) begin
                settle <= settle + 1'b1;
            end

            if (state != S_GAP) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_LAST) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            // Set on entry to FAULT. Cleared only by the go acknowledge,
            // so an abort leaves it standing.
            if (state_n == S_FAULT && state != S_FAULT) begin
                err_q <= 1'b1;
            end else if (state == S_FAULT && state_n == S_GAP) begin
                err_q <= 1'b0;
            end

            if (pop) begin
                q_reg <= mem[rd_ptr];
            end
        end
    end

    assign start       = (state == S_RUN);
    assign enable      = (state == S_RUN);
    assign busy        = (state != S_IDLE);
    assign sp_done     = (state == S_DONE);
    assign timeout_err = err_q;
    assign q_desired   = q_reg;
    assign fifo_count  = count;

endmodule

// File: tb/tb_q_setpoint_scheduler.sv
module tb_q_setpoint_scheduler;

    localparam int BW     = 10;
    localparam int DEPTH  = 4;
    localparam int TW     = 14;
    localparam int TO     = 50;
    localparam int SETTLE = 8;
    localparam int GAP    = 4;

`ifdef Q_SCHED_RETRY_EN
    localparam int WINDOWS = 2;
`else
    localparam int WINDOWS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sp_valid;
    logic [BW-1:0] sp_data;
    logic          sp_ready;
    logic          go;
    logic          abort;
    logic          converged;
    logic          start;
    logic          enable;
    logic [BW-1:0] q_desired;
    logic          busy;
    logic          sp_done;
    logic          timeout_err;
    logic [2:0]    fifo_count;

    q_setpoint_scheduler #(
        .BUS_WIDTH      (BW),
        .DEPTH          (DEPTH),
        .TIMEOUT_W      (TW),
        .TIMEOUT_CYCLES (TO),
        .SETTLE_CYCLES  (SETTLE),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sp_valid    (sp_valid),
        .sp_data     (sp_data),
        .sp_ready    (sp_ready),
        .go          (go),
        .abort       (abort),
        .converged   (converged),
        .start       (start),
        .enable      (enable),
        .q_desired   (q_desired),
        .busy        (busy),
        .sp_done     (sp_done),
        .timeout_err (timeout_err),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the queue contents: what the FIFO should hold.
    logic [BW-1:0] model_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start"},  32'(start), 0);
        chk({tag, "_enable"}, 32'(enable), 0);
        chk({tag, "_q"},      32'(q_desired), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_done"},   32'(sp_done), 0);
        chk({tag, "_err"},    32'(timeout_err), 0);
        chk({tag, "_count"},  32'(fifo_count), 0);
        chk({tag, "_ready"},  32'(sp_ready), 1);
    endtask

    // One push cycle. A push into a full queue is dropped.
    task automatic push_one(input logic [BW-1:0] v);
        sp_valid = 1'b1;
        sp_data  = v;
        tick();
        sp_valid = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(v);
        chk("push_count", 32'(fifo_count), model_q.size());
        chk("push_ready", 32'(sp_ready), (model_q.size() < DEPTH) ? 1 : 0);
    endtask

    // go in IDLE: one LOAD cycle, then RUN.
    task automatic go_start();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("load_start", 32'(start), 0);
        chk("load_busy", 32'(busy), 1);
        tick();
    endtask

    // Entered on the first RUN cycle of the queue head.
    // converged stays unsettled for low_len cycles, with runs of at most 3.
    // It is then high until the setpoint is accepted, at RUN cycle low_len+SETTLE.
    task automatic run_converge(input int low_len);
        logic [BW-1:0] exp_q;
        int            done_at;
        exp_q   = model_q.pop_front();
        done_at = low_len + SETTLE;
        for (int k = 1; k <= done_at; k++) begin
            if (k > low_len)
                converged = 1'b1;
            else
                converged = (k < low_len) && ((k % 4) != 0) && ($urandom_range(0, 1) == 1);
            if (k == 1) begin
                chk("run_q", 32'(q_desired), 32'(exp_q));
                chk("run_count", 32'(fifo_count), model_q.size());
            end
            chk("run_start", 32'(start), 1);
            chk("run_enable", 32'(enable), 1);
            chk("run_no_done", 32'(sp_done), 0);
            tick();
        end
        converged = 1'b0;
        chk("done_pulse", 32'(sp_done), 1);
        chk("done_start", 32'(start), 0);
        for (int g = 1; g <= GAP; g++) begin
            tick();
            chk("gap_enable", 32'(enable), 0);
            chk("gap_done", 32'(sp_done), 0);
            chk("gap_busy", 32'(busy), 1);
        end
        tick();
        if (model_q.size() > 0) begin
            chk("next_load_busy", 32'(busy), 1);
            chk("next_load_start", 32'(start), 0);
            tick();
        end else begin
            chk("end_idle", 32'(busy), 0);
        end
    endtask

    // Entered on the first RUN cycle of the queue head.
    // converged toggles every 4 cycles, so the setpoint never settles.
    // ack_with_go leaves FAULT with go; otherwise it leaves with abort.
    task automatic run_timeout(input bit ack_with_go);
        logic [BW-1:0] exp_q;
        exp_q = model_q.pop_front();
        for (int w = 1; w <= WINDOWS; w++) begin
            for (int k = 1; k <= TO; k++) begin
                converged = (((k - 1) / 4) % 2) == 0;
                if (k == 1) chk("to_q", 32'(q_desired), 32'(exp_q));
                chk("to_start", 32'(start), 1);
                chk("to_no_done", 32'(sp_done), 0);
                chk("to_err_lo", 32'(timeout_err), 0);
                tick();
            end
            converged = 1'b0;
            if (w < WINDOWS) begin
                chk("retry_gap_en", 32'(enable), 0);
                chk("retry_gap_err", 32'(timeout_err), 0);
                for (int g = 2; g <= GAP; g++) tick();
                tick();
                chk("retry_load_busy", 32'(busy), 1);
                tick();
            end
        end
        chk("fault_err", 32'(timeout_err), 1);
        chk("fault_start", 32'(start), 0);
        chk("fault_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fault_hold_err", 32'(timeout_err), 1);
            chk("fault_hold_en", 32'(enable), 0);
        end
        if (ack_with_go) begin
            go = 1'b1;
            tick();
            go = 1'b0;
            chk("ack_err_clr", 32'(timeout_err), 0);
            chk("ack_gap_busy", 32'(busy), 1);
            for (int g = 2; g <= GAP; g++) tick();
            tick();
            chk("ack_idle", 32'(busy), (model_q.size() > 0) ? 1 : 0);
        end else begin
            abort = 1'b1;
            go    = 1'b1;
            tick();
            abort = 1'b0;
            go    = 1'b0;
            model_q.delete();
            chk("abort_fault_idle", 32'(busy), 0);
            chk("abort_fault_err_kept", 32'(timeout_err), 1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        sp_valid  = 1'b0;
        sp_data   = '0;
        go        = 1'b0;
        abort     = 1'b0;
        converged = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_vals("reset");

        // Three setpoints run to convergence, in order.
        push_one(10'd301);
        push_one(10'd150);
        push_one(10'd500);
        go_start();
        for (int i = 0; i < 3; i++) run_converge($urandom_range(0, 20));
        chk("seq_idle_busy", 32'(busy), 0);

        // Five back-to-back pushes: the fifth is dropped. Drain the four kept.
        for (int i = 0; i < 5; i++) push_one(BW'($urandom_range(0, 1023)));
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(sp_ready), 0);
        go_start();
        for (int i = 0; i < 4; i++) run_converge($urandom_range(0, 20));

        // Watchdog expiry, acknowledged with go; then the empty queue leads to IDLE.
        push_one(10'd301);
        go_start();
        run_timeout(1'b1);

        // abort in RUN cycle 10 flushes the queue. It beats a same-cycle push.
        push_one(BW'($urandom_range(0, 1023)));
        push_one(BW'($urandom_range(0, 1023)));
        go_start();
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin
                abort    = 1'b1;
                sp_valid = 1'b1;
                sp_data  = BW'($urandom_range(0, 1023));
            end
            tick();
        end
        abort    = 1'b0;
        sp_valid = 1'b0;
        model_q.delete();
        chk("abort_start", 32'(start), 0);
        chk("abort_enable", 32'(enable), 0);
        chk("abort_count", 32'(fifo_count), 0);
        chk("abort_busy", 32'(busy), 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("abort_go_empty", 32'(busy), 0);

        // A fault left by abort keeps timeout_err set.
        push_one(BW'($urandom_range(0, 1023)));
        go_start();
        run_timeout(1'b0);

        // rst mid-RUN: reset values on the next cycle; go on an empty queue is ignored.
        push_one(BW'($urandom_range(1, 1023)));
        go_start();
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_start", 32'(start), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_q.delete();
        check_reset_vals("rst_mid_run");
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("post_rst_go_busy", 32'(busy), 0);
        tick();
        chk("post_rst_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
